pc_ifid_stage: RTL and testbench
================================

// Module: pc_ifid_stage
// PURPOSE
//  Program counter register and IF/ID pipeline register for the 5-stage MIPS core.
//  Consumes the final next-PC from the jump/branch/JR mux chain and drives the
//  instruction-memory address.
//  Supplies PC+4 to the PC4-or-branch mux, and the IF/ID latch to decode.
//  Honours load-use stalls from hazard detection and control-transfer flushes.
//  Keeps saturating stall and flush counters for performance debug.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  CNT_W      16             width of the stall and flush counters
// PORTS
//  clk            in   1      core clock; all state updates on rising edge
//  rst            in   1      synchronous, active-high reset
//  next_pc        in   32     selected next PC (output of jr/jump/branch mux chain)
//  redirect       in   1      branch taken / j / jal / jr resolved in ID; flush IF/ID
//  stall          in   1      hazard unit: hold PC and IF/ID (load-use)
//  imem_instr     in   32     instruction read combinationally at address pc
//  pc             out  32     current fetch address to instruction memory
//  pc_plus_4      out  32     pc + 4, combinational, to first_PC4_or_branch_mux In1
//  ifid_instr     out  32     latched instruction to decode
//  ifid_pc_plus_4 out  32     latched PC+4 (jal link value / BTA base)
//  ifid_valid     out  1      1 = latched slot holds a real fetched instruction
//  misalign_err   out  1      sticky: a next_pc with bits[1:0]!=0 was loaded
//  stall_cnt      out  CNT_W  saturating count of cycles with stall && !redirect
//  flush_cnt      out  CNT_W  saturating count of cycles with redirect
// BEHAVIOUR
//  Reset (rst=1 at an edge), regardless of any other input:
//   pc=RESET_PC, ifid_instr=NOP (32'h0), ifid_pc_plus_4=0, ifid_valid=0,
//   misalign_err=0, stall_cnt=0, flush_cnt=0. Reset mid-stall or mid-flush gives the same result.
//  pc_plus_4 = pc + 32'd4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), zero latency.
//  PC update per edge, priority order:
//   redirect             -> pc <= {next_pc[31:2],2'b00}
//   else stall           -> pc holds
//   else                 -> pc <= {next_pc[31:2],2'b00}
//  misalign_err: set on any edge that loads pc from a next_pc with [1:0]!=0.
//   Stays set until rst.
//  IF/ID update per edge, priority order:
//   redirect             -> instr<=NOP, pc_plus_4<=0, valid<=0 (squash the wrong-path fetch)
//   else stall           -> all IF/ID fields hold
//   else                 -> instr<=imem_instr, pc_plus_4<=pc_plus_4, valid<=1
//  redirect && stall together: redirect wins for both PC and IF/ID.
//   stall_cnt does not increment; flush_cnt does.
//  Counters: +1 per qualifying cycle. Hold at {CNT_W{1'b1}}, no wrap.
//  Latency: fetch at cycle N is visible on ifid_* in cycle N+1.
//   A redirect in cycle N makes pc = target in cycle N+1, then the target instruction
//   is in IF/ID in cycle N+2.
//  No X propagation: X on imem_instr during squash or stall never reaches ifid_instr.
// STRUCTURE
//  cpu_pkg: localparam NOP_INSTR=32'h0000_0000, PC_STEP=32'd4, default RESET_PC.
//  Sub-module sat_counter #(W) (clk, rst, inc, count) is instantiated twice
//   (stall_cnt, flush_cnt).
//  PC register, adder and IF/ID register stay inline.
// TESTING
//  1 Reset: rst=1 for 2 cycles with redirect=1, stall=1 -> pc=0, ifid_valid=0,
//    ifid_instr=0, both counters 0.
//  2 Sequential fetch: next_pc=pc_plus_4, imem_instr=32'h2008_0005 -> pc steps 0,4,8.
//    Next cycle: ifid_instr=32'h2008_0005, ifid_pc_plus_4=4, valid=1.
//  3 Stall: pc=8, stall=1 for 3 cycles -> pc stays 8, ifid_* hold, stall_cnt=3.
//    On release, pc=8's next_pc (12).
//  4 Redirect: pc=12, redirect=1, stall=1, next_pc=32'h0000_0040 -> next cycle pc=0x40,
//    ifid_valid=0, ifid_instr=0, flush_cnt=1, stall_cnt unchanged.
//  5 Wrap and misalign: RESET_PC=32'hFFFF_FFFC -> pc_plus_4=0.
//    next_pc=32'h0000_0013 -> pc=32'h0000_0010, misalign_err=1, still 1 after 5 cycles.
//  6 Saturation: CNT_W=3, stall=1 for 10 cycles -> stall_cnt stops at 7.
//    rst=1 mid-run -> 0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the fetch stage of the 5-stage MIPS core
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch addresses are word aligned: drop the byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_ifid_stage_if.sv
// rtl/pc_ifid_stage_if.sv - fetch-stage bus between PC/IF-ID register and the core
interface pc_ifid_stage_if;
  import cpu_pkg::*;

  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus_4;
  logic        ifid_valid;
  logic        misalign_err;

  // Fetch stage side: owns the PC and the IF/ID latch.
  modport master (
    input  next_pc, redirect, stall, imem_instr,
    output pc, pc_plus_4, ifid_instr, ifid_pc_plus_4, ifid_valid, misalign_err
  );

  // Core side: next-PC mux, hazard unit, instruction memory, decode.
  modport slave (
    output next_pc, redirect, stall, imem_instr,
    input  pc, pc_plus_4, ifid_instr, ifid_pc_plus_4, ifid_valid, misalign_err
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_ifid_stage.sv
// rtl/pc_ifid_stage.sv - program counter, PC+4 adder and IF/ID pipeline register
module pc_ifid_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  pc_ifid_stage_if.master    bus,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus_4_w;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_plus_4_q;
  logic        ifid_valid_q;
  logic        misalign_q;
  logic        load_pc;
  logic        stall_only;

  // A redirect overrides a load-use stall: the stalled slot is on the wrong path anyway.
  assign load_pc     = bus.redirect || !bus.stall;
  assign stall_only  = bus.stall && !bus.redirect;
  assign pc_plus_4_w = pc_q + PC_STEP;

  // PC register and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else if (load_pc) begin
      pc_q <= align_word(bus.next_pc);
      if (bus.next_pc[1:0] != 2'b00) begin
        misalign_q <= 1'b1;
      end
    end
  end

  // IF/ID latch: squash on redirect, hold on stall, otherwise capture the fetch.
  always_ff @(posedge clk) begin
    if (rst || bus.redirect) begin
      ifid_instr_q     <= NOP_INSTR;
      ifid_pc_plus_4_q <= '0;
      ifid_valid_q     <= 1'b0;
    end else if (!bus.stall) begin
      ifid_instr_q     <= bus.imem_instr;
      ifid_pc_plus_4_q <= pc_plus_4_w;
      ifid_valid_q     <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_only),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.redirect),
    .count (flush_cnt)
  );

  assign bus.pc             = pc_q;
  assign bus.pc_plus_4      = pc_plus_4_w;
  assign bus.ifid_instr     = ifid_instr_q;
  assign bus.ifid_pc_plus_4 = ifid_pc_plus_4_q;
  assign bus.ifid_valid     = ifid_valid_q;
  assign bus.misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_ifid_stage.sv
// tb/tb_pc_ifid_stage.sv - directed bench for pc_ifid_stage
module tb_pc_ifid_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Default instance
  logic        rst_a = 1'b1;
  logic        use_seq_a = 1'b0;
  logic [31:0] np_a = 32'h0;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  pc_ifid_stage_if a_if ();
  assign a_if.next_pc = use_seq_a ? a_if.pc_plus_4 : np_a;

  pc_ifid_stage u_dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .bus       (a_if.master),
    .stall_cnt (stall_cnt_a),
    .flush_cnt (flush_cnt_a)
  );

  // Wrap-around reset PC and narrow counters
  logic        rst_b = 1'b1;
  logic [2:0]  stall_cnt_b, flush_cnt_b;
  pc_ifid_stage_if b_if ();

  pc_ifid_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .bus       (b_if.master),
    .stall_cnt (stall_cnt_b),
    .flush_cnt (flush_cnt_b)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1; a_if.redirect = 1'b1; a_if.stall = 1'b1;
    use_seq_a = 1'b0; np_a = 32'h0000_0040; a_if.imem_instr = 32'hDEAD_BEEF;
    tick(2);
    tests_run++;
    if (a_if.pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h exp %h", a_if.pc, 32'h0); end
    tests_run++;
    if (a_if.pc_plus_4 !== 32'h4) begin tests_failed++; $display("FAIL reset_pc_plus_4 got %h exp %h", a_if.pc_plus_4, 32'h4); end
    tests_run++;
    if (a_if.ifid_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", a_if.ifid_valid); end
    tests_run++;
    if (a_if.ifid_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got %h exp 0", a_if.ifid_instr); end
    tests_run++;
    if (stall_cnt_a !== 16'd0 || flush_cnt_a !== 16'd0) begin tests_failed++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt_a, flush_cnt_a); end
    tests_run++;
    if (a_if.misalign_err !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got %b exp 0", a_if.misalign_err); end
  endtask

  task automatic test_seq_fetch;
    rst_a = 1'b0; a_if.redirect = 1'b0; a_if.stall = 1'b0;
    use_seq_a = 1'b1; a_if.imem_instr = 32'h2008_0005;
    tick(1);
    tests_run++;
    if (a_if.pc !== 32'h4) begin tests_failed++; $display("FAIL seq_pc1 got %h exp %h", a_if.pc, 32'h4); end
    tests_run++;
    if (a_if.ifid_instr !== 32'h2008_0005 || a_if.ifid_pc_plus_4 !== 32'h4 || a_if.ifid_valid !== 1'b1) begin
      tests_failed++; $display("FAIL seq_ifid1 got %h/%h/%b exp 20080005/00000004/1", a_if.ifid_instr, a_if.ifid_pc_plus_4, a_if.ifid_valid);
    end
    tick(1);
    tests_run++;
    if (a_if.pc !== 32'h8 || a_if.ifid_pc_plus_4 !== 32'h8) begin
      tests_failed++; $display("FAIL seq_pc2 got %h/%h exp 00000008/00000008", a_if.pc, a_if.ifid_pc_plus_4);
    end
  endtask

  task automatic test_stall;
    a_if.stall = 1'b1; a_if.imem_instr = 32'hxxxx_xxxx;
    tick(3);
    tests_run++;
    if (a_if.pc !== 32'h8) begin tests_failed++; $display("FAIL stall_pc got %h exp %h", a_if.pc, 32'h8); end
    tests_run++;
    if (a_if.ifid_instr !== 32'h2008_0005 || a_if.ifid_pc_plus_4 !== 32'h8 || a_if.ifid_valid !== 1'b1) begin
      tests_failed++; $display("FAIL stall_ifid_hold got %h/%h/%b exp 20080005/00000008/1", a_if.ifid_instr, a_if.ifid_pc_plus_4, a_if.ifid_valid);
    end
    tests_run++;
    if (stall_cnt_a !== 16'd3) begin tests_failed++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt_a); end
    a_if.stall = 1'b0; a_if.imem_instr = 32'h8C09_0000;
    tick(1);
    tests_run++;
    if (a_if.pc !== 32'hC || a_if.ifid_instr !== 32'h8C09_0000 || a_if.ifid_pc_plus_4 !== 32'hC) begin
      tests_failed++; $display("FAIL stall_release got %h/%h/%h exp 0000000c/8c090000/0000000c", a_if.pc, a_if.ifid_instr, a_if.ifid_pc_plus_4);
    end
  endtask

  task automatic test_redirect;
    a_if.redirect = 1'b1; a_if.stall = 1'b1; use_seq_a = 1'b0;
    np_a = 32'h0000_0040; a_if.imem_instr = 32'hxxxx_xxxx;
    tick(1);
    tests_run++;
    if (a_if.pc !== 32'h40) begin tests_failed++; $display("FAIL redir_pc got %h exp %h", a_if.pc, 32'h40); end
    tests_run++;
    if (a_if.ifid_valid !== 1'b0 || a_if.ifid_instr !== 32'h0 || a_if.ifid_pc_plus_4 !== 32'h0) begin
      tests_failed++; $display("FAIL redir_squash got %b/%h/%h exp 0/00000000/00000000", a_if.ifid_valid, a_if.ifid_instr, a_if.ifid_pc_plus_4);
    end
    tests_run++;
    if (flush_cnt_a !== 16'd1 || stall_cnt_a !== 16'd3) begin
      tests_failed++; $display("FAIL redir_counters got %0d/%0d exp flush 1 stall 3", flush_cnt_a, stall_cnt_a);
    end
    a_if.redirect = 1'b0; a_if.stall = 1'b0; use_seq_a = 1'b1; a_if.imem_instr = 32'h0000_1234;
    tick(1);
    tests_run++;
    if (a_if.pc !== 32'h44 || a_if.ifid_instr !== 32'h0000_1234 || a_if.ifid_pc_plus_4 !== 32'h44 || a_if.ifid_valid !== 1'b1) begin
      tests_failed++; $display("FAIL redir_target_fetch got %h/%h/%h/%b exp 00000044/00001234/00000044/1", a_if.pc, a_if.ifid_instr, a_if.ifid_pc_plus_4, a_if.ifid_valid);
    end
    tests_run++;
    if (a_if.misalign_err !== 1'b0) begin tests_failed++; $display("FAIL redir_misalign got %b exp 0", a_if.misalign_err); end
  endtask

  task automatic test_back_to_back;
    a_if.redirect = 1'b1; use_seq_a = 1'b0; np_a = 32'h0000_0100;
    tick(1);
    np_a = 32'h0000_0200;
    tick(1);
    tests_run++;
    if (a_if.pc !== 32'h200 || a_if.ifid_valid !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_pc got %h/%b exp 00000200/0", a_if.pc, a_if.ifid_valid);
    end
    tests_run++;
    if (flush_cnt_a !== 16'd3 || stall_cnt_a !== 16'd3) begin
      tests_failed++; $display("FAIL b2b_counters got %0d/%0d exp flush 3 stall 3", flush_cnt_a, stall_cnt_a);
    end
    a_if.redirect = 1'b0;
  endtask

  task automatic test_wrap_misalign;
    tests_run++;
    if (b_if.pc !== 32'hFFFF_FFFC || b_if.pc_plus_4 !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_pc_plus_4 got %h/%h exp fffffffc/00000000", b_if.pc, b_if.pc_plus_4);
    end
    rst_b = 1'b0; b_if.redirect = 1'b0; b_if.stall = 1'b0;
    b_if.next_pc = 32'h0000_0013; b_if.imem_instr = 32'h0000_0020;
    tick(1);
    tests_run++;
    if (b_if.pc !== 32'h10 || b_if.misalign_err !== 1'b1) begin
      tests_failed++; $display("FAIL misalign_load got %h/%b exp 00000010/1", b_if.pc, b_if.misalign_err);
    end
    tests_run++;
    if (b_if.ifid_pc_plus_4 !== 32'h0 || b_if.ifid_valid !== 1'b1) begin
      tests_failed++; $display("FAIL wrap_ifid got %h/%b exp 00000000/1", b_if.ifid_pc_plus_4, b_if.ifid_valid);
    end
    b_if.next_pc = 32'h0000_0014;
    tick(5);
    tests_run++;
    if (b_if.pc !== 32'h14 || b_if.misalign_err !== 1'b1) begin
      tests_failed++; $display("FAIL misalign_sticky got %h/%b exp 00000014/1", b_if.pc, b_if.misalign_err);
    end
  endtask

  task automatic test_saturation;
    b_if.stall = 1'b1;
    tick(6);
    tests_run++;
    if (stall_cnt_b !== 3'd6) begin tests_failed++; $display("FAIL sat_mid got %0d exp 6", stall_cnt_b); end
    tick(4);
    tests_run++;
    if (stall_cnt_b !== 3'd7) begin tests_failed++; $display("FAIL sat_hold got %0d exp 7", stall_cnt_b); end
    rst_b = 1'b1;
    tick(1);
    tests_run++;
    if (stall_cnt_b !== 3'd0 || flush_cnt_b !== 3'd0 || b_if.misalign_err !== 1'b0 || b_if.pc !== 32'hFFFF_FFFC) begin
      tests_failed++; $display("FAIL sat_reset got %0d/%0d/%b/%h exp 0/0/0/fffffffc", stall_cnt_b, flush_cnt_b, b_if.misalign_err, b_if.pc);
    end
  endtask

  initial begin
    b_if.redirect = 1'b1; b_if.stall = 1'b1;
    b_if.next_pc = 32'h0; b_if.imem_instr = 32'h0;
    test_reset();
    test_seq_fetch();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap_misalign();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
